// File: rtl/hud_text_sequencer.sv
// HUD text refresh sequencer: snapshots N_FIELDS game counters and writes each
// one as two ASCII digits into the character RAM through a stallable write port.
//
//  state     | meaning
//  ----------+--------------------------------------------------------------
//  S_IDLE    | waiting for update_req, or a frame_tick with a changed value
//  S_LOAD    | capture clamped values_in into the working snapshot, idx = 0
//  S_CONV    | shared converter turns field idx into tens/ones characters
//  S_WR_TENS | write tens character, held until wr_ready
//  S_WR_ONES | write ones character, then next field or finish
//  S_DONE    | done pulse, commit last-written snapshot, restart if pending
module hud_text_sequencer #(
   parameter int N_FIELDS     = 4,
   parameter int ADDR_W       = 7,
   parameter int BASE_ADDR    = 0,
   parameter int FIELD_STRIDE = 4,
   parameter int BLANK_LZ     = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    update_req,
   input  logic                    frame_tick,
   input  logic [8*N_FIELDS-1:0]   values_in,
   input  logic                    wr_ready,
   output logic                    wr_en,
   output logic [ADDR_W-1:0]       wr_addr,
   output logic [6:0]              wr_data,
   output logic                    busy,
   output logic                    done
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_CONV    = 3'd2;
   localparam logic [2:0] S_WR_TENS = 3'd3;
   localparam logic [2:0] S_WR_ONES = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   localparam int IDX_W = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FIELDS - 1);

   logic [2:0]                 state_q, state_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [N_FIELDS-1:0][7:0]   snap_q, snap_d;
   logic [N_FIELDS-1:0][7:0]   last_q, last_d;
   logic [6:0]                 tens_chr_q, tens_chr_d;
   logic [6:0]                 ones_chr_q, ones_chr_d;
   logic                       pending_q, pending_d;

   logic [N_FIELDS-1:0][7:0]   clamped;
   logic [N_FIELDS-1:0][7:0]   ref_snap;
   logic                       changed;
   logic                       trig;
   logic [7:0]                 conv_val;
   logic [3:0]                 conv_tens;
   logic [3:0]                 conv_ones;
   logic [ADDR_W-1:0]          field_addr;

   always_comb begin
      for (int i = 0; i < N_FIELDS; i++) begin
         clamped[i] = (values_in[8*i +: 8] > 8'd99) ? 8'd99 : values_in[8*i +: 8];
      end
   end

   // In DONE the working snapshot is what is about to become the last-written one.
   assign ref_snap = (state_q == S_DONE) ? snap_q : last_q;
   assign changed  = (clamped != ref_snap);
   assign trig     = update_req || (frame_tick && changed);

   assign conv_val = snap_q[idx_q];

   always_comb begin
      conv_tens = 4'd0;
      for (int k = 1; k < 10; k++) begin
         if (conv_val >= 8'(10 * k)) conv_tens = 4'(k);
      end
      conv_ones = 4'(conv_val - 8'(10 * conv_tens));
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      snap_d     = snap_q;
      last_d     = last_q;
      tens_chr_d = tens_chr_q;
      ones_chr_d = ones_chr_q;
      pending_d  = pending_q;

      if (state_q != S_IDLE && state_q != S_DONE && trig) pending_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (trig) state_d = S_LOAD;
         end
         S_LOAD: begin
            snap_d  = clamped;
            idx_d   = '0;
            state_d = S_CONV;
         end
         S_CONV: begin
            tens_chr_d = ((BLANK_LZ != 0) && (conv_tens == 4'd0)) ? 7'h20 : {3'b011, conv_tens};
            ones_chr_d = {3'b011, conv_ones};
            state_d    = S_WR_TENS;
         end
         S_WR_TENS: begin
            if (wr_ready) state_d = S_WR_ONES;
         end
         S_WR_ONES: begin
            if (wr_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_CONV;
               end
            end
         end
         S_DONE: begin
            last_d    = snap_q;
            pending_d = 1'b0;
            state_d   = (pending_q || trig) ? S_LOAD : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         snap_q     <= '0;
         last_q     <= '1;
         tens_chr_q <= '0;
         ones_chr_q <= '0;
         pending_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         snap_q     <= snap_d;
         last_q     <= last_d;
         tens_chr_q <= tens_chr_d;
         ones_chr_q <= ones_chr_d;
         pending_q  <= pending_d;
      end
   end

   // Address arithmetic wraps modulo 2^ADDR_W.
   assign field_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(FIELD_STRIDE) * ADDR_W'(idx_q);

   assign wr_en   = (state_q == S_WR_TENS) || (state_q == S_WR_ONES);
   assign wr_addr = (state_q == S_WR_TENS) ? field_addr :
                    (state_q == S_WR_ONES) ? field_addr + ADDR_W'(1) : '0;
   assign wr_data = (state_q == S_WR_TENS) ? tens_chr_q :
                    (state_q == S_WR_ONES) ? ones_chr_q : 7'd0;
   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_hud_text_sequencer.sv
// Directed bench for hud_text_sequencer: write order, latency, stalls,
// pending requests, clamping, change detection and mid-refresh reset.
module tb_hud_text_sequencer;

   logic        clk;
   logic        rst;
   logic        update_req;
   logic        frame_tick;
   logic [31:0] values_in;
   logic        wr_ready;
   logic        wr_en;
   logic [6:0]  wr_addr;
   logic [6:0]  wr_data;
   logic        busy;
   logic        done;

   hud_text_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .update_req (update_req),
      .frame_tick (frame_tick),
      .values_in  (values_in),
      .wr_ready   (wr_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [13:0] wq[$];
   logic [13:0] expq[$];
   int          done_cyc[$];
   int          busy_cnt;
   int          busy_first;
   int          t0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!rst) begin
         if (wr_en && wr_ready) wq.push_back({wr_addr, wr_data});
         if (done) done_cyc.push_back(cyc);
         if (busy) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = cyc;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_sb();
      wq.delete();
      expq.delete();
      done_cyc.delete();
      busy_cnt   = 0;
      busy_first = -1;
   endtask

   task automatic set_vals(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
      values_in = {d, c, b, a};
   endtask

   task automatic exp_field(input int idx, input logic [6:0] t, input logic [6:0] o);
      logic [6:0] a;
      a = 7'(4 * idx);
      expq.push_back({a, t});
      expq.push_back({a + 7'd1, o});
   endtask

   task automatic pulse_req();
      update_req = 1'b1;
      t0 = cyc;
      tick();
      update_req = 1'b0;
   endtask

   task automatic pulse_tick();
      frame_tick = 1'b1;
      t0 = cyc;
      tick();
      frame_tick = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int n, input int budget);
      int k;
      k = 0;
      while (done_cyc.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk({tag, "_done_seen"}, done_cyc.size(), n);
   endtask

   task automatic check_writes(input string tag);
      chk({tag, "_nwrites"}, wq.size(), expq.size());
      for (int i = 0; i < expq.size(); i++) begin
         if (i < wq.size()) chk($sformatf("%s_wr%0d", tag, i), wq[i], expq[i]);
      end
   endtask

   initial begin
      rst        = 1'b1;
      update_req = 1'b0;
      frame_tick = 1'b0;
      values_in  = '0;
      wr_ready   = 1'b1;
      clear_sb();

      repeat (3) tick();
      chk("rst_wr_en", wr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      rst = 1'b0;
      repeat (2) tick();

      // Basic refresh, leading-zero blanking
      set_vals(8'd7, 8'd42, 8'd99, 8'd0);
      clear_sb();
      pulse_req();
      wait_done("basic", 1, 40);
      repeat (2) tick();
      exp_field(0, 7'h20, 7'h37);
      exp_field(1, 7'h34, 7'h32);
      exp_field(2, 7'h39, 7'h39);
      exp_field(3, 7'h20, 7'h30);
      check_writes("basic");
      if (done_cyc.size() > 0) chk("basic_done_cyc", done_cyc[0], t0 + 14);
      chk("basic_busy_first", busy_first, t0 + 1);
      chk("basic_busy_cnt", busy_cnt, 14);
      chk("basic_busy_idle", busy, 0);

      // Clamp 200 -> 99, then 250 (also 99) is no change
      set_vals(8'd7, 8'd200, 8'd99, 8'd0);
      clear_sb();
      pulse_tick();
      wait_done("clamp", 1, 40);
      repeat (2) tick();
      exp_field(0, 7'h20, 7'h37);
      exp_field(1, 7'h39, 7'h39);
      exp_field(2, 7'h39, 7'h39);
      exp_field(3, 7'h20, 7'h30);
      check_writes("clamp");
      set_vals(8'd7, 8'd250, 8'd99, 8'd0);
      clear_sb();
      pulse_tick();
      repeat (20) tick();
      chk("nochg_writes", wq.size(), 0);
      chk("nochg_done", done_cyc.size(), 0);
      chk("nochg_busy", busy_cnt, 0);

      // Stall field 2 tens write for 3 cycles
      clear_sb();
      pulse_req();
      repeat (8) tick();
      wr_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         chk($sformatf("stall_wr_en%0d", s), wr_en, 1);
         chk($sformatf("stall_addr%0d", s), wr_addr, 8);
         chk($sformatf("stall_data%0d", s), wr_data, 7'h39);
         if (s < 2) tick();
      end
      tick();
      wr_ready = 1'b1;
      wait_done("stall", 1, 40);
      repeat (2) tick();
      exp_field(0, 7'h20, 7'h37);
      exp_field(1, 7'h39, 7'h39);
      exp_field(2, 7'h39, 7'h39);
      exp_field(3, 7'h20, 7'h30);
      check_writes("stall");
      if (done_cyc.size() > 0) chk("stall_done_cyc", done_cyc[0], t0 + 17);

      // Pending: three requests during a refresh collapse into one rerun
      set_vals(8'd1, 8'd2, 8'd3, 8'd4);
      clear_sb();
      pulse_req();
      tick();
      set_vals(8'd11, 8'd22, 8'd33, 8'd44);
      repeat (3) tick();
      update_req = 1'b1;
      tick();
      tick();
      update_req = 1'b0;
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      wait_done("pend", 2, 80);
      repeat (30) tick();
      exp_field(0, 7'h20, 7'h31);
      exp_field(1, 7'h20, 7'h32);
      exp_field(2, 7'h20, 7'h33);
      exp_field(3, 7'h20, 7'h34);
      exp_field(0, 7'h31, 7'h31);
      exp_field(1, 7'h32, 7'h32);
      exp_field(2, 7'h33, 7'h33);
      exp_field(3, 7'h34, 7'h34);
      check_writes("pend");
      chk("pend_done_count", done_cyc.size(), 2);
      if (done_cyc.size() > 1) begin
         chk("pend_done0_cyc", done_cyc[0], t0 + 14);
         chk("pend_done1_cyc", done_cyc[1], t0 + 28);
      end
      chk("pend_busy_cnt", busy_cnt, 28);

      // Reset during field 2 ones write
      set_vals(8'd5, 8'd6, 8'd7, 8'd8);
      clear_sb();
      pulse_req();
      repeat (9) tick();
      chk("rmid_wr_en_before", wr_en, 1);
      chk("rmid_addr_before", wr_addr, 9);
      rst = 1'b1;
      #1;
      chk("rmid_wr_en", wr_en, 0);
      chk("rmid_busy", busy, 0);
      chk("rmid_done", done, 0);
      chk("rmid_writes", wq.size(), 5);
      repeat (3) tick();
      rst = 1'b0;
      repeat (10) tick();
      chk("rmid_writes_after", wq.size(), 5);
      chk("rmid_no_done", done_cyc.size(), 0);
      clear_sb();
      pulse_tick();
      wait_done("rpost", 1, 40);
      repeat (2) tick();
      exp_field(0, 7'h20, 7'h35);
      exp_field(1, 7'h20, 7'h36);
      exp_field(2, 7'h20, 7'h37);
      exp_field(3, 7'h20, 7'h38);
      check_writes("rpost");
      if (done_cyc.size() > 0) chk("rpost_done_cyc", done_cyc[0], t0 + 14);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hud_text_sequencer.md
Name: hud_text_sequencer

Overview:
- Sequences the HUD text refresh: snapshots N_FIELDS numeric game values (score, round, ammo, timer), converts each to two ASCII digits through one time-shared 0–99 binary-to-ASCII converter, and writes the characters into the text character RAM.
- Sits between Game_Control counters and the text-line buffer read by the display path.
- Write-port handshake lets the RAM owner stall writes.

Parameters:
- N_FIELDS, 4: number of numeric fields; field i occupies values_in[8*i+7:8*i].
- ADDR_W, 7: character RAM address width.
- BASE_ADDR, 0: RAM address of field 0 tens digit.
- FIELD_STRIDE, 4: address distance between consecutive fields; must be >= 2.
- BLANK_LZ, 1: when 1, the tens digit of a value below 10 is written as space (7'h20) instead of '0'.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- update_req  input  1  single-cycle forced refresh request
- frame_tick  input  1  single-cycle tick; starts a refresh only if any field differs from the last written snapshot
- values_in  input  8*N_FIELDS  unsigned field values
- wr_ready  input  1  RAM accepts the write this cycle
- wr_en  output  1  write request, held until accepted
- wr_addr  output  ADDR_W  character address
- wr_data  output  7  ASCII character
- busy  output  1  refresh in progress
- done  output  1  one-cycle pulse when the last character of a refresh is accepted

Behaviour:
- Reset (async, rst=1): state IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, pending=0; last-written snapshot = all ones (8'hFF per field) so the first frame_tick always refreshes.
- Trigger in IDLE: update_req=1, or frame_tick=1 with values_in != last snapshot. Next cycle is LOAD.
- FSM states: IDLE -> LOAD -> CONV -> WR_TENS -> WR_ONES -> (CONV for next field | DONE) -> IDLE.
- LOAD, 1 cycle:
  - Register values_in into the working snapshot.
  - Each field is clamped: values > 99 become 99.
  - Field index = 0; busy=1 from this cycle.
- CONV, 1 cycle:
  - Drive the shared converter with the snapshot of the current field.
  - Register tens and ones ASCII; apply BLANK_LZ substitution.
- WR_TENS:
  - wr_en=1, wr_addr=BASE_ADDR+FIELD_STRIDE*idx, wr_data=tens character.
  - Stays in state, outputs stable, until wr_ready=1; transfer occurs on the cycle wr_en&&wr_ready.
- WR_ONES:
  - Same as WR_TENS, with wr_addr+1 and the ones character.
  - On accept: if idx == N_FIELDS-1, go to DONE; else idx+1 and go to CONV.
- wr_en is 0 in IDLE, LOAD, CONV and DONE.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- DONE, 1 cycle:
  - done=1.
  - Last-written snapshot <= working snapshot (the clamped values).
  - busy stays 1 during DONE and drops in the following IDLE cycle.
- Latency with wr_ready held 1:
  - Trigger at cycle T: LOAD at T+1, first write T+3.
  - done at T+2+3*N_FIELDS (T+14 for N_FIELDS=4).
  - Each wr_ready=0 cycle adds exactly one cycle.
- Requests while busy:
  - update_req, or a frame_tick with a change, sets pending.
  - In DONE, if pending=1, pending clears and the next state is LOAD (busy stays 1, no IDLE cycle). Otherwise the next state is IDLE.
  - Multiple requests collapse into one.
- values_in changes mid-refresh do not affect the current refresh; only the LOAD-cycle snapshot is written.
- Simultaneous update_req and frame_tick is a single trigger.
- Change detection compares clamped values_in to the last snapshot. A field moving from 120 to 130 (both clamp to 99) is no change.
- Reset asserted mid-write: immediate return to reset values; a partially written line is not completed.

Test Plan:
- Reset, values {field0=7, 1=42, 2=99, 3=0}, update_req at T, wr_ready=1 -> 8 writes, addr/data in order:
  - 0/0x20, 1/0x37
  - 4/0x34, 5/0x32
  - 8/0x39, 9/0x39
  - 12/0x20, 13/0x30
  - done pulse at T+14, busy high T+1..T+14.
- Field1=200 -> written as '9','9' at addr 4/5. A frame_tick afterwards with field1=250 produces no refresh.
- wr_ready low for 3 cycles during field2 tens write -> wr_en/wr_addr=8/wr_data=0x39 held stable, no duplicate write, done delayed by exactly 3 cycles.
- update_req during field1 of a refresh, with values_in changed after LOAD:
  - The current refresh writes the old values.
  - done is followed directly by LOAD, and the second refresh writes the new values.
- Exactly one extra refresh occurs even with 3 requests issued.
- rst asserted while in WR_ONES of field 2 -> wr_en, busy and done drop asynchronously, no further writes. After release, the first frame_tick triggers a full refresh (snapshot reinitialised to 8'hFF).
